// File: rtl/bcd_seq_conv_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// State encodings are fixed so that bench and downstream logic agree on them.
package bcd_seq_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int ITER_COUNT = 8;
  localparam int BCD_DIGITS = 3;
  localparam int BIN_W      = 8;
  localparam int DIGIT_W    = 4;
  localparam int BCD_W      = DIGIT_W * BCD_DIGITS;
  localparam int CNT_W      = $clog2(ITER_COUNT);

endpackage

// File: rtl/bcd_seq_conv_if.sv
// Operand/result handshake bundle of the converter.
// The slave side is the converter itself; the master side is whoever drives operands.
interface bcd_seq_conv_if;
  import bcd_seq_conv_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [BIN_W-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DIGIT_W-1:0] ONES;
  logic [DIGIT_W-1:0] TENS;
  logic [DIGIT_W-1:0] HUNDREDS;
  logic               busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, ONES, TENS, HUNDREDS, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, ONES, TENS, HUNDREDS, busy
  );

endinterface

// File: rtl/bcd_seq_conv_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decade.
module add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = (din >= 4'd5) ? din + 4'd3 : din;
  end

endmodule

// File: rtl/bcd_seq_conv.sv
// Sequential 8-bit binary to 3-digit BCD converter (iterative double-dabble).
// One operand bit is consumed per SHIFT cycle; the result is held until the next one completes.
module bcd_seq_conv
  import bcd_seq_conv_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  bcd_seq_conv_if.slave bus
);

  state_t                   state_q, state_d;
  logic                     alive_q;
  logic [BIN_W-1:0]         bin_q;
  logic [BCD_W-1:0]         scratch_q;
  logic [BCD_W-1:0]         scratch_adj;
  logic [CNT_W-1:0]         cnt_q;
  logic [BCD_W-1:0]         result_q;
  logic [BCD_W+BIN_W-1:0]   shifted;
  logic                     accept;
  logic                     last_iter;

  for (genvar d = 0; d < BCD_DIGITS; d++) begin : g_digit
    add3 u_add3 (
      .din  (scratch_q  [DIGIT_W*d +: DIGIT_W]),
      .dout (scratch_adj[DIGIT_W*d +: DIGIT_W])
    );
  end

  // Correction first, then the whole {scratch, operand} pair moves up one bit.
  assign shifted   = {scratch_adj, bin_q} << 1;
  assign last_iter = (cnt_q == CNT_W'(ITER_COUNT - 1));
  assign accept    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (last_iter) state_d = DONE;
      DONE: begin
        if (accept)             state_d = SHIFT;
        else if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // alive_q keeps in_ready low until the first edge after reset release.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    unique case (state_q)
      IDLE:  bus.in_ready = alive_q;
      SHIFT: bus.busy     = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = alive_q && bus.out_ready;
      end
      default: ;
    endcase
  end

  // NOTE: datapath registers are reset too, so an abandoned conversion leaves nothing visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive_q   <= 1'b0;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      alive_q <= 1'b1;
      if (accept) begin
        bin_q     <= bus.in_data;
        scratch_q <= '0;
        cnt_q     <= '0;
      end else if (state_q == SHIFT) begin
        {scratch_q, bin_q} <= shifted;
        cnt_q              <= cnt_q + 1'b1;
        if (last_iter) begin
          result_q <= shifted[BCD_W+BIN_W-1 -: BCD_W];
        end
      end
    end
  end

  assign bus.ONES     = result_q[0*DIGIT_W +: DIGIT_W];
  assign bus.TENS     = result_q[1*DIGIT_W +: DIGIT_W];
  assign bus.HUNDREDS = result_q[2*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Self-checking bench for bcd_seq_conv: transaction-level model checked every cycle,
// plus directed conversions with literal expected digits and a randomized 0..255 sweep.
module tb_bcd_seq_conv;
  import bcd_seq_conv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks    = 0;
  int   n_errors    = 0;
  int   n_accepted  = 0;
  int   n_delivered = 0;

  bcd_seq_conv_if bus ();

  bcd_seq_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: a conversion accepted at edge k presents its result from edge k+8 onward.
  bit          m_alive    = 1'b0;
  bit          m_inflight = 1'b0;
  bit          m_hold     = 1'b0;
  logic [11:0] m_digits   = '0;
  logic [7:0]  m_operand  = '0;
  int          edge_n     = 0;
  int          m_finish   = 0;
  logic [7:0]  exp_q[$];

  function automatic logic [11:0] bcd_of(int x);
    return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic bit exp_ready();
    return m_alive && !m_inflight && (!m_hold || bus.out_ready);
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc;
    acc = bus.in_valid && exp_ready();
    if (m_hold && bus.out_ready) m_hold = 1'b0;
    if (m_inflight && edge_n == m_finish) begin
      m_inflight = 1'b0;
      m_hold     = 1'b1;
      m_digits   = bcd_of(int'(m_operand));
    end
    if (acc) begin
      m_inflight = 1'b1;
      m_finish   = edge_n + 8;
      m_operand  = bus.in_data;
      exp_q.push_back(bus.in_data);
      n_accepted++;
    end
    m_alive = 1'b1;
    edge_n++;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_alive    = 1'b0;
      m_inflight = 1'b0;
      m_hold     = 1'b0;
      m_digits   = '0;
      exp_q.delete();
    end else begin
      model_edge();
    end
  end

  // Per-cycle comparison against the model, plus a scoreboard on every output handshake.
  initial begin
    logic [7:0] v;
    forever begin
      @(negedge clk);
      check("out_valid", 12'(bus.out_valid), 12'(m_hold));
      check("busy",      12'(bus.busy),      12'(m_inflight));
      check("in_ready",  12'(bus.in_ready),  12'(exp_ready()));
      check("digits",    {bus.HUNDREDS, bus.TENS, bus.ONES}, m_digits);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        check("pending_results", 12'(exp_q.size()), 12'd1);
        if (exp_q.size() > 0) begin
          v = exp_q.pop_front();
          check("handshake_result", {bus.HUNDREDS, bus.TENS, bus.ONES}, bcd_of(int'(v)));
          n_delivered++;
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until out_valid, scrambling in_data meanwhile; n counts edges after the accept edge.
  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      bus.in_data = 8'($urandom);
      tick();
      n++;
    end
    check("wait_out_valid", 12'(bus.out_valid), 12'd1);
  endtask

  initial begin
    int n;
    int budget;
    int sweep_base;
    bit done;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    repeat (3) tick();
    check("rst_in_ready",  12'(bus.in_ready),  12'd0);
    check("rst_out_valid", 12'(bus.out_valid), 12'd0);
    check("rst_digits", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h000);
    #2 rst_n = 1'b1;
    tick();
    check("in_ready_after_release", 12'(bus.in_ready), 12'd1);

    // 255 -> 2/5/5; latency counted including the load edge.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFF;
    tick();
    bus.in_valid = 1'b0;
    check("busy_after_accept", 12'(bus.busy), 12'd1);
    wait_valid(n);
    check("latency_255", 12'(n + 1), 12'd9);
    check("result_255", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h255);
    bus.out_ready = 1'b1;
    tick();
    check("valid_drop_255", 12'(bus.out_valid), 12'd0);
    check("retain_255", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h255);
    bus.out_ready = 1'b0;

    // 0 then 99 back-to-back, in_valid held high throughout.
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b1;
    tick();
    wait_valid(n);
    check("latency_0", 12'(n + 1), 12'd9);
    check("result_0", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h000);
    bus.in_data = 8'd99;
    tick();
    check("no_bubble_busy", 12'(bus.busy), 12'd1);
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("latency_99", 12'(n + 1), 12'd9);
    check("result_99", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h099);
    tick();
    check("idle_after_99", 12'(bus.out_valid), 12'd0);

    // 128 under 20 cycles of backpressure, in_valid kept high to prove it is ignored.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'd128;
    tick();
    wait_valid(n);
    check("latency_128", 12'(n + 1), 12'd9);
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'($urandom);
      tick();
      check("bp_valid",    12'(bus.out_valid), 12'd1);
      check("bp_in_ready", 12'(bus.in_ready),  12'd0);
      check("bp_result", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h128);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", 12'(bus.out_valid), 12'd0);
    check("bp_release_busy",  12'(bus.busy),      12'd0);

    // Reset during the fifth shift cycle of 200, then convert 7.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd200;
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check("midrst_digits", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h000);
    check("midrst_valid",    12'(bus.out_valid), 12'd0);
    check("midrst_busy",     12'(bus.busy),      12'd0);
    check("midrst_in_ready", 12'(bus.in_ready),  12'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("ready_after_midrst", 12'(bus.in_ready), 12'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd7;
    tick();
    bus.in_valid = 1'b0;
    wait_valid(n);
    check("result_7", {bus.HUNDREDS, bus.TENS, bus.ONES}, 12'h007);
    tick();

    // Sweep 0..255 with random input gaps and random consumer stalls.
    sweep_base = n_delivered;
    for (int v = 0; v < 256; v++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(v);
      done   = 1'b0;
      budget = 0;
      while (!done && budget < 200) begin
        bus.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        done = bus.in_ready;
        tick();
        budget++;
      end
      check("sweep_accept", 12'(done), 12'd1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (12) tick();
    check("sweep_delivered", 12'(n_delivered - sweep_base), 12'd256);
    check("queue_drained",   12'(exp_q.size()),             12'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
